mem_responder: RTL and testbench

Memory-side responder for the core's data memory read/write handshake. Accepts one word request at a time from the core (read strobe, write strobe, address, write data). Services it from an internal word-addressed array after a fixed, parameterised latency. Returns the result with a one-cycle valid pulse. It sits between the core's memory port and the backing storage, and acts as the target that answers the core's `mem_read`/`mem_valid` exchange.

---
 rtl/mem_responder.sv | 111 +++++++++++
 tb/tb_mem_responder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Word-addressed memory target for the core's read/write handshake.
// Requests complete after a fixed latency and are answered with a one-cycle valid pulse.
module mem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic        clock_in,
   input  logic        reset_in,
   input  logic        mem_read_in,
   input  logic        mem_write_in,
   input  logic [31:0] mem_addr_in,
   input  logic [31:0] mem_wdata_in,
   output logic        mem_busy_out,
   output logic        mem_valid_out,
   output logic [31:0] mem_data_out,
   output logic        mem_err_out
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state;
   logic [3:0]       count;
   logic [IDX_W-1:0] req_idx;
   logic [31:0]      req_wdata;
   logic             req_write;
   logic             req_err;

   logic [31:0]      mem [DEPTH_WORDS];

   logic accept;
   logic misaligned;
   logic out_of_range;
   logic both_strobes;
   logic access;
   logic wr_en;

   assign misaligned   = (mem_addr_in[1:0] != 2'b00);
   assign out_of_range = ({2'b00, mem_addr_in[31:2]} >= 32'(DEPTH_WORDS));
   assign both_strobes = mem_read_in & mem_write_in;

   // New requests are taken only when nothing is in flight; RESP overlaps the next accept.
   assign accept = (state != WAIT) && (mem_read_in || mem_write_in);
   assign access = (state == WAIT) && (count == 4'd0);
   assign wr_en  = access && req_write && !req_err;

   // NOTE: the array has no reset; contents survive reset, and an aborted write never
   // commits because the async reset forces the state out of WAIT before the next edge.
   always_ff @(posedge clock_in) begin
      if (wr_en)
         mem[req_idx] <= req_wdata;
   end

   // NOTE: all sequential state uses non-blocking assignments so every register samples
   // pre-edge values, independent of statement order.
   always_ff @(posedge clock_in or negedge reset_in) begin
      if (!reset_in) begin
         state         <= IDLE;
         count         <= 4'd0;
         req_idx       <= '0;
         req_wdata     <= 32'h0;
         req_write     <= 1'b0;
         req_err       <= 1'b0;
         mem_busy_out  <= 1'b0;
         mem_valid_out <= 1'b0;
         mem_data_out  <= 32'h0;
         mem_err_out   <= 1'b0;
      end else begin
         mem_valid_out <= 1'b0;
         mem_err_out   <= 1'b0;
         case (state)
            IDLE, RESP: begin
               if (accept) begin
                  req_idx      <= mem_addr_in[IDX_W+1:2];
                  req_wdata    <= mem_wdata_in;
                  req_write    <= mem_write_in;
                  req_err      <= misaligned | out_of_range | both_strobes;
                  count        <= 4'(LATENCY - 1);
                  state        <= WAIT;
                  mem_busy_out <= 1'b1;
               end else begin
                  state        <= IDLE;
                  mem_busy_out <= 1'b0;
               end
            end
            WAIT: begin
               if (count == 4'd0) begin
                  state         <= RESP;
                  mem_busy_out  <= 1'b0;
                  mem_valid_out <= 1'b1;
                  mem_err_out   <= req_err;
                  // Only a clean read returns array data; writes and rejects return zero.
                  mem_data_out  <= (req_err || req_write) ? 32'h0 : mem[req_idx];
               end else begin
                  count <= count - 4'd1;
               end
            end
            default: begin
               state        <= IDLE;
               mem_busy_out <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with LATENCY = 2 and DEPTH_WORDS = 1024.
// Each task drives one scenario and compares outputs against hand-derived values.
module tb_mem_responder;

   localparam int DEPTH = 1024;
   localparam int LAT   = 2;

   logic        clk;
   logic        rst_n;
   logic        mem_read_in;
   logic        mem_write_in;
   logic [31:0] mem_addr_in;
   logic [31:0] mem_wdata_in;
   logic        mem_busy_out;
   logic        mem_valid_out;
   logic [31:0] mem_data_out;
   logic        mem_err_out;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
      .clock_in      (clk),
      .reset_in      (rst_n),
      .mem_read_in   (mem_read_in),
      .mem_write_in  (mem_write_in),
      .mem_addr_in   (mem_addr_in),
      .mem_wdata_in  (mem_wdata_in),
      .mem_busy_out  (mem_busy_out),
      .mem_valid_out (mem_valid_out),
      .mem_data_out  (mem_data_out),
      .mem_err_out   (mem_err_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Issues one request and waits (bounded) for its response.
   task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, output logic got, output logic [31:0] data,
                         output logic err, output int lat, output int busy_n);
      got = 1'b0; data = 32'h0; err = 1'b0; lat = 0; busy_n = 0;
      @(posedge clk); #1;
      mem_read_in = rd; mem_write_in = wr; mem_addr_in = addr; mem_wdata_in = wd;
      @(posedge clk); #1;
      mem_read_in = 1'b0; mem_write_in = 1'b0;
      if (mem_busy_out) busy_n++;
      for (int k = 1; k <= 20 && !got; k++) begin
         @(posedge clk); #1;
         if (mem_valid_out) begin
            got = 1'b1; data = mem_data_out; err = mem_err_out; lat = k;
         end else if (mem_busy_out) begin
            busy_n++;
         end
      end
   endtask

   task automatic test_reset;
      int busy_seen;
      busy_seen = 0;
      rst_n = 1'b0;
      mem_read_in = 1'b0; mem_write_in = 1'b0; mem_addr_in = 32'h0; mem_wdata_in = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({mem_busy_out, mem_valid_out, mem_err_out, mem_data_out} !== 35'h0) begin
         errors++;
         $display("FAIL reset_hold: busy=%b valid=%b err=%b data=%h, expected all 0",
                  mem_busy_out, mem_valid_out, mem_err_out, mem_data_out);
      end
      rst_n = 1'b1;
      repeat (4) begin
         @(posedge clk); #1;
         if (mem_busy_out) busy_seen++;
      end
      checks++;
      if (busy_seen !== 0) begin
         errors++;
         $display("FAIL reset_idle_busy: busy cycles=%0d, expected 0", busy_seen);
      end
      checks++;
      if ({mem_valid_out, mem_err_out, mem_data_out} !== 34'h0) begin
         errors++;
         $display("FAIL reset_idle_out: valid=%b err=%b data=%h, expected all 0",
                  mem_valid_out, mem_err_out, mem_data_out);
      end
   endtask

   task automatic test_write_read;
      logic got, err; logic [31:0] data; int lat, busy_n;
      do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, got, data, err, lat, busy_n);
      checks++;
      if (got !== 1'b1 || lat !== LAT) begin
         errors++;
         $display("FAIL wr_latency: got=%b lat=%0d, expected got=1 lat=%0d", got, lat, LAT);
      end
      checks++;
      if (data !== 32'h0 || err !== 1'b0) begin
         errors++;
         $display("FAIL wr_resp: data=%h err=%b, expected 00000000 0", data, err);
      end
      checks++;
      if (busy_n !== LAT) begin
         errors++;
         $display("FAIL wr_busy: busy cycles=%0d, expected %0d", busy_n, LAT);
      end
      @(posedge clk); #1;
      checks++;
      if (mem_valid_out !== 1'b0 || mem_err_out !== 1'b0) begin
         errors++;
         $display("FAIL wr_pulse_width: valid=%b err=%b one cycle later, expected 0 0",
                  mem_valid_out, mem_err_out);
      end
      do_req(1'b1, 1'b0, 32'h10, 32'h0, got, data, err, lat, busy_n);
      checks++;
      if (got !== 1'b1 || lat !== LAT || data !== 32'hDEADBEEF || err !== 1'b0) begin
         errors++;
         $display("FAIL rd_after_wr: got=%b lat=%0d data=%h err=%b, expected 1 %0d deadbeef 0",
                  got, lat, data, err, LAT);
      end
      checks++;
      if (busy_n !== LAT) begin
         errors++;
         $display("FAIL rd_busy: busy cycles=%0d, expected %0d", busy_n, LAT);
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (mem_data_out !== 32'hDEADBEEF || mem_valid_out !== 1'b0) begin
         errors++;
         $display("FAIL data_hold: data=%h valid=%b, expected deadbeef 0",
                  mem_data_out, mem_valid_out);
      end
   endtask

   task automatic test_back_to_back;
      int first_c, second_c;
      first_c = -1; second_c = -1;
      @(posedge clk); #1;
      mem_write_in = 1'b1; mem_addr_in = 32'h0; mem_wdata_in = 32'hCAFEF00D;
      @(posedge clk); #1;
      mem_write_in = 1'b0;
      for (int k = 0; k < 20 && first_c < 0; k++) begin
         @(posedge clk); #1;
         if (mem_valid_out) first_c = cyc;
      end
      // Present the read during the write's RESP cycle.
      mem_read_in = 1'b1; mem_addr_in = 32'h0;
      @(posedge clk); #1;
      mem_read_in = 1'b0;
      checks++;
      if (mem_busy_out !== 1'b1 || mem_valid_out !== 1'b0) begin
         errors++;
         $display("FAIL b2b_accept: busy=%b valid=%b after RESP edge, expected 1 0",
                  mem_busy_out, mem_valid_out);
      end
      for (int k = 0; k < 20 && second_c < 0; k++) begin
         if (mem_valid_out) second_c = cyc;
         else begin @(posedge clk); #1; end
      end
      checks++;
      if (first_c < 0 || second_c < 0 || (second_c - first_c) !== LAT + 1) begin
         errors++;
         $display("FAIL b2b_spacing: first=%0d second=%0d, expected gap %0d",
                  first_c, second_c, LAT + 1);
      end
      checks++;
      if (mem_data_out !== 32'hCAFEF00D || mem_err_out !== 1'b0) begin
         errors++;
         $display("FAIL b2b_data: data=%h err=%b, expected cafef00d 0", mem_data_out, mem_err_out);
      end
   endtask

   task automatic test_errors;
      logic got, err; logic [31:0] data; int lat, busy_n;
      logic [31:0] addr_v [6];
      logic        rd_v   [6];
      logic        wr_v   [6];
      addr_v = '{32'h2, 32'h4 * DEPTH, 32'h4, 32'h6, 32'h4 * DEPTH, 32'h4 * DEPTH + 32'h4};
      rd_v   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      wr_v   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      do_req(1'b0, 1'b1, 32'h0, 32'h11111111, got, data, err, lat, busy_n);
      do_req(1'b0, 1'b1, 32'h4, 32'h33333333, got, data, err, lat, busy_n);
      do_req(1'b1, 1'b0, 32'h0, 32'h0, got, data, err, lat, busy_n);
      checks++;
      if (data !== 32'h11111111 || err !== 1'b0) begin
         errors++;
         $display("FAIL err_setup: data=%h err=%b, expected 11111111 0", data, err);
      end
      for (int i = 0; i < 6; i++) begin
         do_req(rd_v[i], wr_v[i], addr_v[i], 32'h5A5A0000 + i, got, data, err, lat, busy_n);
         checks++;
         if (got !== 1'b1 || lat !== LAT || err !== 1'b1 || data !== 32'h0) begin
            errors++;
            $display("FAIL err_case%0d: got=%b lat=%0d err=%b data=%h, expected 1 %0d 1 00000000",
                     i, got, lat, err, data, LAT);
         end
      end
      do_req(1'b1, 1'b0, 32'h0, 32'h0, got, data, err, lat, busy_n);
      checks++;
      if (data !== 32'h11111111 || err !== 1'b0) begin
         errors++;
         $display("FAIL err_word0_intact: data=%h err=%b, expected 11111111 0", data, err);
      end
      do_req(1'b1, 1'b0, 32'h4, 32'h0, got, data, err, lat, busy_n);
      checks++;
      if (data !== 32'h33333333 || err !== 1'b0) begin
         errors++;
         $display("FAIL err_word1_intact: data=%h err=%b, expected 33333333 0", data, err);
      end
   endtask

   task automatic test_busy_drop;
      int pulses; logic [31:0] last;
      pulses = 0; last = 32'h0;
      @(posedge clk); #1;
      mem_read_in = 1'b1; mem_addr_in = 32'h10;
      @(posedge clk); #1;
      mem_addr_in = 32'h4;
      @(posedge clk); #1;
      mem_read_in = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (mem_valid_out) begin pulses++; last = mem_data_out; end
         @(posedge clk); #1;
      end
      checks++;
      if (pulses !== 1 || last !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL busy_drop: pulses=%0d data=%h, expected 1 deadbeef", pulses, last);
      end
   endtask

   task automatic test_reset_mid_write;
      logic got, err; logic [31:0] data; int lat, busy_n, pulses;
      pulses = 0;
      do_req(1'b0, 1'b1, 32'h8, 32'hA5A5A5A5, got, data, err, lat, busy_n);
      do_req(1'b1, 1'b0, 32'h8, 32'h0, got, data, err, lat, busy_n);
      @(posedge clk); #1;
      mem_write_in = 1'b1; mem_addr_in = 32'h8; mem_wdata_in = 32'h12345678;
      @(posedge clk); #1;
      mem_write_in = 1'b0;
      checks++;
      if (mem_busy_out !== 1'b1 || mem_data_out !== 32'hA5A5A5A5) begin
         errors++;
         $display("FAIL rst_mid_pre: busy=%b data=%h, expected 1 a5a5a5a5",
                  mem_busy_out, mem_data_out);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({mem_busy_out, mem_valid_out, mem_err_out, mem_data_out} !== 35'h0) begin
         errors++;
         $display("FAIL rst_mid_async: busy=%b valid=%b err=%b data=%h, expected all 0",
                  mem_busy_out, mem_valid_out, mem_err_out, mem_data_out);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         if (mem_valid_out) pulses++;
      end
      checks++;
      if (pulses !== 0) begin
         errors++;
         $display("FAIL rst_mid_no_pulse: pulses=%0d, expected 0", pulses);
      end
      do_req(1'b1, 1'b0, 32'h8, 32'h0, got, data, err, lat, busy_n);
      checks++;
      if (got !== 1'b1 || data !== 32'hA5A5A5A5 || err !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_old_data: got=%b data=%h err=%b, expected 1 a5a5a5a5 0",
                  got, data, err);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_back_to_back();
      test_errors();
      test_busy_drop();
      test_reset_mid_write();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
